midi_voice_alloc: RTL
=====================

// Module: midi_voice_alloc
// PURPOSE
//  Polyphonic voice allocator/scheduler between the MIDI parser and the oscillator bank.
//  Accepts note-on/off events, assigns each note to a voice slot and shares one
//  midi_freq_lut instance across all voices. Emits one voice-update per event
//  carrying the voice index, frequency (Hz x1000) and velocity.
// PARAMETERS
//  NUM_VOICES  8  number of voice slots (2..16)
//  AGE_W       8  width of the per-voice saturating age counter
// PORTS
//  clk               in   1              system clock
//  rst               in   1              async reset, active-high
//  evt_valid         in   1              event present
//  evt_ready         out  1              allocator can accept event
//  evt_note_on       in   1              1=note-on, 0=note-off
//  evt_note          in   7              MIDI note number
//  evt_velocity      in   7              MIDI velocity
//  upd_valid         out  1              one-cycle voice-update strobe
//  upd_voice         out  $clog2(NV)     voice index updated
//  upd_freq_x1000    out  24             frequency of voice (Hz x1000)
//  upd_velocity      out  7              velocity (0 = voice released)
//  voice_active      out  NUM_VOICES     per-voice active flags
//  evt_dropped       out  1              one-cycle pulse: note-on discarded
// BEHAVIOUR
//  Clock and reset: one clock clk; reset rst is asynchronous and active-high.
//  Reset: state=IDLE; evt_ready=1; upd_valid=0; upd_voice=0; upd_freq_x1000=0;
//   upd_velocity=0; voice_active=0; evt_dropped=0; all note/age tables cleared.
//  Reset mid-event: the in-flight event is discarded and no update is emitted.
//  Handshake: an event is accepted on an edge with evt_valid&&evt_ready.
//   evt_ready=1 only in IDLE. Fields are captured on the accepting edge.
//  FSM: IDLE -accept-> SCAN -> COMMIT -> IDLE. Throughput is 1 event per 3 cycles.
//   SCAN: one cycle; computes the target voice and registers the LUT output for the
//    captured note.
//   COMMIT: tables are written; upd_* are registered and upd_valid is high for
//    exactly the cycle after the COMMIT edge. evt_ready is high again in that same cycle.
//  Note-on with evt_velocity==0 is treated as note-off.
//  Note-on target priority:
//   (1) active voice already holding the same note: retrigger it, new velocity;
//   (2) lowest-index inactive voice;
//   (3) all voices active: see CONFIGURATION.
//  On allocation:
//   - voice_active[v] set; note stored; age[v] cleared.
//   - Every other active voice's age increments, saturating at 2^AGE_W-1.
//   - upd_freq_x1000 = LUT(note); upd_velocity = evt_velocity.
//  Note-off: lowest-index active voice holding that note is cleared.
//   - The update carries upd_velocity=0 and that voice's last frequency.
//   - No match: no update, no drop pulse; FSM still passes through SCAN/COMMIT.
//  Oldest voice = maximum age, lowest index wins ties.
//  voice_active changes on the COMMIT edge, coincident with upd_valid.
// CONFIGURATION
//  MIDI_VOICE_STEAL_EN defined:
//   - With all voices active, a note-on steals the oldest voice.
//   - The update is emitted as a normal allocation; evt_dropped stays 0.
//  MIDI_VOICE_STEAL_EN undefined:
//   - With all voices active, a note-on is discarded: no update, tables untouched.
//   - evt_dropped pulses for one cycle, aligned to where upd_valid would have been.
// STRUCTURE
//  Shared package midi_pkg:
//   - note_t (7b), vel_t (7b), freq_t (24b);
//   - alloc_state_t enum {IDLE, SCAN, COMMIT}.
//  Sub-module: one instance of midi_freq_lut (note_t in, freq_t out), placed in SCAN.
//  Voice search (match, free, oldest) is combinational inside this module, over the tables.
// TESTING
//  1. Reset; note-on 69 vel 100 -> 3rd cycle: upd_valid, voice 0, freq 440000,
//     vel 100, voice_active=8'h01.
//  2. Note-on 60 then 64 -> voices 0 and 1, freqs 261626 and 329628;
//     note-off 60 -> voice 0, vel 0, active=8'h02.
//  3. Note-on 72 vel 0 after note-on 72 -> treated as note-off: update vel 0,
//     voice cleared; note-off 50 (absent) -> no update.
//  4. Fill 8 voices with notes 60..67, then note-on 80:
//     - with MIDI_VOICE_STEAL_EN -> voice 0 (oldest), freq 830609;
//     - without -> evt_dropped pulse, no upd_valid.
//  5. Hold evt_valid high for back-to-back events -> evt_ready low for SCAN and COMMIT
//     cycles; one accept per 3 cycles, none lost.
//  6. Assert rst during SCAN -> no upd_valid afterwards, voice_active=0, evt_ready=1.

Source files
------------

// File: rtl/midi_pkg.sv
// midi_pkg: shared MIDI types, allocator state encodings and the top-octave
// frequency reference used by midi_freq_lut.
package midi_pkg;

  typedef logic [6:0]  note_t;
  typedef logic [6:0]  vel_t;
  typedef logic [23:0] freq_t;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    COMMIT
  } alloc_state_t;

  typedef enum logic [1:0] {
    ACT_NONE,
    ACT_ALLOC,
    ACT_RELEASE,
    ACT_DROP
  } alloc_action_t;

  // Reference octave is MIDI octave 10 (notes 120..131); values carry 16 fraction bits.
  localparam int LUT_FRAC_W = 16;
  localparam int TOP_OCTAVE = 10;
  localparam int REF_W      = 40;

  // Frequency (Hz x1000, Q24.16) of pitch class pc in octave 10.
  function automatic logic [REF_W-1:0] octave_ref(input logic [3:0] pc);
    case (pc)
      4'd0:    return {24'd8372018,  16'd5873};
      4'd1:    return {24'd8869844,  16'd12534};
      4'd2:    return {24'd9397272,  16'd37576};
      4'd3:    return {24'd9956063,  16'd31399};
      4'd4:    return {24'd10548081, 16'd53819};
      4'd5:    return {24'd11175303, 16'd26598};
      4'd6:    return {24'd11839821, 16'd34523};
      4'd7:    return {24'd12543853, 16'd62352};
      4'd8:    return {24'd13289750, 16'd21139};
      4'd9:    return {24'd14080000, 16'd0};
      4'd10:   return {24'd14917240, 16'd24155};
      default: return {24'd15804265, 16'd41956};
    endcase
  endfunction

endpackage

// File: rtl/midi_freq_lut.sv
// midi_freq_lut: MIDI note number to frequency (Hz x1000), rounded to nearest.
// Each octave is the octave-10 reference halved, so only 12 constants are stored.
module midi_freq_lut
  import midi_pkg::*;
(
  input  note_t note,
  output freq_t freq
);

  logic [3:0]       octave;
  logic [3:0]       pitch;
  logic [4:0]       shift;
  logic [REF_W-1:0] ref_val;
  logic [REF_W-1:0] half;

  assign octave  = 4'(note / 7'd12);
  assign pitch   = 4'(note % 7'd12);
  assign ref_val = octave_ref(pitch);

  // Dropping the fraction bits and one halving per octave below 10 in a single shift.
  assign shift = 5'(LUT_FRAC_W + TOP_OCTAVE) - 5'(octave);
  assign half  = REF_W'(1) << (shift - 5'd1);
  assign freq  = freq_t'((ref_val + half) >> shift);

endmodule

// File: rtl/midi_voice_alloc.sv
// midi_voice_alloc: polyphonic voice allocator between the MIDI parser and the oscillators.
// Define MIDI_VOICE_STEAL_EN to steal the oldest voice when all are busy; otherwise the note-on is dropped.
module midi_voice_alloc
  import midi_pkg::*;
#(
  parameter int NUM_VOICES = 8,
  parameter int AGE_W      = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          evt_valid,
  output logic                          evt_ready,
  input  logic                          evt_note_on,
  input  logic [6:0]                    evt_note,
  input  logic [6:0]                    evt_velocity,
  output logic                          upd_valid,
  output logic [$clog2(NUM_VOICES)-1:0] upd_voice,
  output logic [23:0]                   upd_freq_x1000,
  output logic [6:0]                    upd_velocity,
  output logic [NUM_VOICES-1:0]         voice_active,
  output logic                          evt_dropped
);

  localparam int VW = $clog2(NUM_VOICES);

  alloc_state_t  state, state_nxt;
  alloc_action_t act_nxt, act_q;
  logic [VW-1:0] tgt_nxt, tgt_q;

  logic  cap_on;
  note_t cap_note;
  vel_t  cap_vel;
  freq_t lut_freq;
  freq_t freq_q;

  note_t                  note_tab [NUM_VOICES];
  logic [AGE_W-1:0]       age_tab  [NUM_VOICES];
  logic [NUM_VOICES-1:0]  active;

  logic          match_found, free_found;
  logic [VW-1:0] match_idx, free_idx;
`ifdef MIDI_VOICE_STEAL_EN
  logic [VW-1:0]    oldest_idx;
  logic [AGE_W-1:0] oldest_age;
`endif

  midi_freq_lut u_lut (
    .note (cap_note),
    .freq (lut_freq)
  );

  // Downward scans leave the lowest matching index in place.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latch is inferred.
    match_found = 1'b0;
    match_idx   = '0;
    free_found  = 1'b0;
    free_idx    = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (active[i] && note_tab[i] == cap_note) begin
        match_found = 1'b1;
        match_idx   = VW'(i);
      end
      if (!active[i]) begin
        free_found = 1'b1;
        free_idx   = VW'(i);
      end
    end
`ifdef MIDI_VOICE_STEAL_EN
    // Strict compare on an upward scan: ties go to the lowest index.
    oldest_idx = '0;
    oldest_age = age_tab[0];
    for (int i = 1; i < NUM_VOICES; i++) begin
      if (age_tab[i] > oldest_age) begin
        oldest_age = age_tab[i];
        oldest_idx = VW'(i);
      end
    end
`endif
  end

  always_comb begin
    state_nxt = state;
    act_nxt   = ACT_NONE;
    tgt_nxt   = '0;
    evt_ready = (state == IDLE);
    case (state)
      IDLE: begin
        if (evt_valid) state_nxt = SCAN;
      end
      SCAN: begin
        state_nxt = COMMIT;
        if (!cap_on) begin
          if (match_found) begin
            act_nxt = ACT_RELEASE;
            tgt_nxt = match_idx;
          end
        end else if (match_found) begin
          act_nxt = ACT_ALLOC;
          tgt_nxt = match_idx;
        end else if (free_found) begin
          act_nxt = ACT_ALLOC;
          tgt_nxt = free_idx;
        end else begin
`ifdef MIDI_VOICE_STEAL_EN
          act_nxt = ACT_ALLOC;
          tgt_nxt = oldest_idx;
`else
          act_nxt = ACT_DROP;
`endif
        end
      end
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cap_on   <= 1'b0;
      cap_note <= '0;
      cap_vel  <= '0;
      act_q    <= ACT_NONE;
      tgt_q    <= '0;
      freq_q   <= '0;
    end else begin
      // NOTE: sequential state is written with non-blocking assignments only.
      state <= state_nxt;
      if (evt_valid && evt_ready) begin
        // A note-on with zero velocity is a note-off.
        cap_on   <= evt_note_on && (evt_velocity != '0);
        cap_note <= evt_note;
        cap_vel  <= evt_velocity;
      end
      if (state == SCAN) begin
        act_q  <= act_nxt;
        tgt_q  <= tgt_nxt;
        freq_q <= lut_freq;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the voice tables are small register arrays, so they are reset with everything else.
      active <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        note_tab[i] <= '0;
        age_tab[i]  <= '0;
      end
      upd_valid      <= 1'b0;
      upd_voice      <= '0;
      upd_freq_x1000 <= '0;
      upd_velocity   <= '0;
      evt_dropped    <= 1'b0;
    end else begin
      upd_valid   <= 1'b0;
      evt_dropped <= 1'b0;
      if (state == COMMIT) begin
        case (act_q)
          ACT_ALLOC: begin
            for (int i = 0; i < NUM_VOICES; i++) begin
              if (tgt_q == VW'(i)) begin
                active[i]   <= 1'b1;
                note_tab[i] <= cap_note;
                age_tab[i]  <= '0;
              end else if (active[i] && age_tab[i] != '1) begin
                age_tab[i] <= age_tab[i] + AGE_W'(1);
              end
            end
            upd_valid      <= 1'b1;
            upd_voice      <= tgt_q;
            upd_freq_x1000 <= freq_q;
            upd_velocity   <= cap_vel;
          end
          ACT_RELEASE: begin
            // Same note as stored, so the LUT result is the voice's last frequency.
            active[tgt_q]  <= 1'b0;
            upd_valid      <= 1'b1;
            upd_voice      <= tgt_q;
            upd_freq_x1000 <= freq_q;
            upd_velocity   <= '0;
          end
          ACT_DROP: evt_dropped <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign voice_active = active;

endmodule
